// File: rtl/morse_pkg.sv
// Shared definitions for the Morse decoder: FSM encoding, sizing defaults
// and ASCII constants.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACK    = 2'd2,
        ST_SPACE  = 2'd3
    } state_t;

    localparam int unsigned MAX_LEN_DEF = 5;  // elements per symbol
    localparam int unsigned SYM_LEN_W   = 3;  // width of the element counter
    localparam int unsigned LUT_W       = 5;  // longest pattern in the table

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse table: LSB-first element bits (dot=0, dash=1) plus
// length in, ASCII letter/digit out with a valid flag.
module morse_lut
    import morse_pkg::*;
(
    input  logic [LUT_W-1:0]     symbol,
    input  logic [SYM_LEN_W-1:0] len,
    output logic [7:0]           ascii,
    output logic                 valid
);

    logic [LUT_W-1:0] val;

    // Re-pack to reading order (first element is MSB of a len-bit value) so
    // the table below reads like the written code, then look it up.
    always_comb begin
        val = '0;
        for (int unsigned i = 0; i < LUT_W; i++) begin
            if (i < 32'(len)) val = {val[LUT_W-2:0], symbol[i]};
        end
        ascii = 8'h00;
        valid = 1'b1;
        case ({len, val})
            {3'd2, 5'b00001}: ascii = 8'h41; // A .-
            {3'd4, 5'b01000}: ascii = 8'h42; // B -...
            {3'd4, 5'b01010}: ascii = 8'h43; // C -.-.
            {3'd3, 5'b00100}: ascii = 8'h44; // D -..
            {3'd1, 5'b00000}: ascii = 8'h45; // E .
            {3'd4, 5'b00010}: ascii = 8'h46; // F ..-.
            {3'd3, 5'b00110}: ascii = 8'h47; // G --.
            {3'd4, 5'b00000}: ascii = 8'h48; // H ....
            {3'd2, 5'b00000}: ascii = 8'h49; // I ..
            {3'd4, 5'b00111}: ascii = 8'h4A; // J .---
            {3'd3, 5'b00101}: ascii = 8'h4B; // K -.-
            {3'd4, 5'b00100}: ascii = 8'h4C; // L .-..
            {3'd2, 5'b00011}: ascii = 8'h4D; // M --
            {3'd2, 5'b00010}: ascii = 8'h4E; // N -.
            {3'd3, 5'b00111}: ascii = 8'h4F; // O ---
            {3'd4, 5'b00110}: ascii = 8'h50; // P .--.
            {3'd4, 5'b01101}: ascii = 8'h51; // Q --.-
            {3'd3, 5'b00010}: ascii = 8'h52; // R .-.
            {3'd3, 5'b00000}: ascii = 8'h53; // S ...
            {3'd1, 5'b00001}: ascii = 8'h54; // T -
            {3'd3, 5'b00001}: ascii = 8'h55; // U ..-
            {3'd4, 5'b00001}: ascii = 8'h56; // V ...-
            {3'd3, 5'b00011}: ascii = 8'h57; // W .--
            {3'd4, 5'b01001}: ascii = 8'h58; // X -..-
            {3'd4, 5'b01011}: ascii = 8'h59; // Y -.--
            {3'd4, 5'b01100}: ascii = 8'h5A; // Z --..
            {3'd5, 5'b11111}: ascii = 8'h30; // 0 -----
            {3'd5, 5'b01111}: ascii = 8'h31; // 1 .----
            {3'd5, 5'b00111}: ascii = 8'h32; // 2 ..---
            {3'd5, 5'b00011}: ascii = 8'h33; // 3 ...--
            {3'd5, 5'b00001}: ascii = 8'h34; // 4 ....-
            {3'd5, 5'b00000}: ascii = 8'h35; // 5 .....
            {3'd5, 5'b10000}: ascii = 8'h36; // 6 -....
            {3'd5, 5'b11000}: ascii = 8'h37; // 7 --...
            {3'd5, 5'b11100}: ascii = 8'h38; // 8 ---..
            {3'd5, 5'b11110}: ascii = 8'h39; // 9 ----.
            default:          valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse decoder: collects dot/dash events from an upstream timer over a
// four-phase writing/read handshake and emits ASCII characters and spaces.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int unsigned MAX_LEN  = MAX_LEN_DEF,
    parameter logic [7:0]  CHAR_ERR = ASCII_QMARK
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dot,
    input  logic                 dash,
    input  logic                 interchar,
    input  logic                 interword,
    input  logic                 writing,
    input  logic                 flush,
    output logic                 read,
    output logic [7:0]           char_out,
    output logic                 char_valid,
    output logic [SYM_LEN_W-1:0] sym_len
);

    state_t                state_q, state_d;
    logic [MAX_LEN-1:0]    symbol_q, symbol_d;
    logic [SYM_LEN_W-1:0]  sym_len_q, sym_len_d;
    logic                  ovf_q, ovf_d;
    logic                  word_open_q, word_open_d;
    logic [7:0]            char_out_q, char_out_d;
    logic                  char_valid_q, char_valid_d;

    logic [7:0]            lut_char;
    logic                  lut_valid;
    logic [7:0]            sym_char;
    logic                  pending;
    logic                  do_emit;

    morse_lut u_lut (
        .symbol (LUT_W'(symbol_q)),
        .len    (sym_len_q),
        .ascii  (lut_char),
        .valid  (lut_valid)
    );

    assign pending  = (sym_len_q != '0);
    assign sym_char = (ovf_q || !lut_valid) ? CHAR_ERR : lut_char;

    // State and datapath registers; reset aborts any event in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            symbol_q     <= '0;
            sym_len_q    <= '0;
            ovf_q        <= 1'b0;
            word_open_q  <= 1'b0;
            char_out_q   <= '0;
            char_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            symbol_q     <= symbol_d;
            sym_len_q    <= sym_len_d;
            ovf_q        <= ovf_d;
            word_open_q  <= word_open_d;
            char_out_q   <= char_out_d;
            char_valid_q <= char_valid_d;
        end
    end

    // Next-state, symbol accumulation and character/space emission.
    always_comb begin
        state_d      = state_q;
        symbol_d     = symbol_q;
        sym_len_d    = sym_len_q;
        ovf_d        = ovf_q;
        word_open_d  = word_open_q;
        char_out_d   = char_out_q;
        char_valid_d = 1'b0;
        do_emit      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (writing)              state_d = ST_SETTLE;
                else if (flush && pending) do_emit = 1'b1;
            end
            ST_SETTLE: begin
                state_d = ST_ACK;
                if (interword) begin
                    do_emit = pending;
                    // A character emitted here also opens the word, so the
                    // space follows it one cycle later via SPACE.
                    if (word_open_q || pending) state_d = ST_SPACE;
                end else if (interchar) begin
                    do_emit = pending;
                end else if (dash || dot) begin
                    if (sym_len_q == SYM_LEN_W'(MAX_LEN)) begin
                        ovf_d = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < MAX_LEN; i++) begin
                            if (i == 32'(sym_len_q)) symbol_d[i] = dash;
                        end
                        sym_len_d = sym_len_q + SYM_LEN_W'(1);
                    end
                end
            end
            ST_SPACE: begin
                char_out_d   = ASCII_SPACE;
                char_valid_d = 1'b1;
                word_open_d  = 1'b0;
                state_d      = ST_ACK;
            end
            ST_ACK: begin
                if (!writing) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_emit) begin
            char_out_d   = sym_char;
            char_valid_d = 1'b1;
            symbol_d     = '0;
            sym_len_d    = '0;
            ovf_d        = 1'b0;
            word_open_d  = 1'b1;
        end
    end

    assign read       = (state_q == ST_ACK) || (state_q == ST_SPACE);
    assign char_out   = char_out_q;
    assign char_valid = char_valid_q;
    assign sym_len    = sym_len_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder: drives upstream events over the
// writing/read handshake and checks emitted characters against hand values.
module tb_morse_decoder;
    import morse_pkg::*;

    logic       clk;
    logic       reset;
    logic       dot, dash, interchar, interword, writing, flush;
    logic       read;
    logic [7:0] char_out;
    logic       char_valid;
    logic [2:0] sym_len;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    logic [7:0]  emit_q[$];
    int unsigned emit_cyc[$];

    morse_decoder #(.MAX_LEN(5), .CHAR_ERR(8'h3F)) dut (
        .clk        (clk),
        .reset      (reset),
        .dot        (dot),
        .dash       (dash),
        .interchar  (interchar),
        .interword  (interword),
        .writing    (writing),
        .flush      (flush),
        .read       (read),
        .char_out   (char_out),
        .char_valid (char_valid),
        .sym_len    (sym_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and capture of every char_valid pulse.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (char_valid) begin
            emit_q.push_back(char_out);
            emit_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // One upstream event: raise writing with flags, wait for read, hold for
    // 'hold' extra cycles, drop writing, wait for read to fall.
    task automatic send_event(input logic d, input logic ds, input logic ic,
                              input logic iw, input logic fl, input int hold);
        int unsigned n;
        @(posedge clk); #1;
        dot = d; dash = ds; interchar = ic; interword = iw;
        writing = 1'b1; flush = fl;
        n = 0;
        do begin
            @(posedge clk); #1;
            flush = 1'b0;
            n++;
        end while (!read && n < 10);
        check("read_rise", read, 1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("read_hold", read, 1);
        end
        writing = 1'b0; dot = 1'b0; dash = 1'b0; interchar = 1'b0; interword = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (read && n < 10);
        check("read_fall", read, 0);
    endtask

    task automatic ev_dot();   send_event(1, 0, 0, 0, 0, 0); endtask
    task automatic ev_dash();  send_event(0, 1, 0, 0, 0, 0); endtask
    task automatic ev_char();  send_event(0, 0, 1, 0, 0, 0); endtask
    task automatic ev_word();  send_event(0, 0, 0, 1, 0, 0); endtask

    initial begin
        int unsigned n;
        reset = 1'b0;
        dot = 0; dash = 0; interchar = 0; interword = 0; writing = 0; flush = 0;
        idle(3);
        check("rst_read", read, 0);
        check("rst_valid", char_valid, 0);
        check("rst_char", char_out, 8'h00);
        check("rst_len", sym_len, 0);
        reset = 1'b1;
        idle(2);

        // No leading space right after reset.
        emit_q.delete(); emit_cyc.delete();
        ev_word();
        idle(2);
        check("lead_space_cnt", emit_q.size(), 0);

        // "E"
        ev_dot();
        check("e_len", sym_len, 1);
        ev_char();
        idle(1);
        check("e_cnt", emit_q.size(), 1);
        if (emit_q.size() > 0) check("e_char", emit_q[0], 8'h45);
        check("e_len_clr", sym_len, 0);

        // "A" then word boundary, read held while writing stays high.
        emit_q.delete(); emit_cyc.delete();
        ev_dot();
        ev_dash();
        check("a_len", sym_len, 2);
        send_event(0, 0, 0, 1, 0, 3);
        idle(1);
        check("a_cnt", emit_q.size(), 2);
        if (emit_q.size() == 2) begin
            check("a_char", emit_q[0], 8'h41);
            check("a_space", emit_q[1], 8'h20);
            check("a_space_gap", emit_cyc[1] - emit_cyc[0], 1);
        end

        // Second word boundary with nothing pending: no repeated space.
        emit_q.delete(); emit_cyc.delete();
        ev_word();
        idle(1);
        check("dup_space_cnt", emit_q.size(), 0);

        // "0": five dashes.
        for (int i = 0; i < 5; i++) ev_dash();
        check("zero_len", sym_len, 5);
        ev_char();
        idle(1);
        check("zero_cnt", emit_q.size(), 1);
        if (emit_q.size() > 0) check("zero_char", emit_q[0], 8'h30);

        // Six dots: overflow saturates and maps to the error code.
        emit_q.delete(); emit_cyc.delete();
        for (int i = 0; i < 6; i++) ev_dot();
        check("ovf_len", sym_len, 5);
        ev_char();
        idle(1);
        check("ovf_cnt", emit_q.size(), 1);
        if (emit_q.size() > 0) check("ovf_char", emit_q[0], 8'h3F);

        // Four dashes: valid length but not in the table.
        emit_q.delete(); emit_cyc.delete();
        for (int i = 0; i < 4; i++) ev_dash();
        ev_char();
        idle(1);
        check("unk_cnt", emit_q.size(), 1);
        if (emit_q.size() > 0) check("unk_char", emit_q[0], 8'h3F);

        // Flush in IDLE with "T" buffered.
        emit_q.delete(); emit_cyc.delete();
        ev_dash();
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_valid", char_valid, 1);
        idle(2);
        check("flush_cnt", emit_q.size(), 1);
        if (emit_q.size() > 0) check("flush_char", emit_q[0], 8'h54);
        check("flush_len", sym_len, 0);

        // Flush coincident with writing rise is dropped; the dash is kept.
        emit_q.delete(); emit_cyc.delete();
        ev_dot();
        send_event(0, 1, 0, 0, 1, 0);
        idle(1);
        check("fw_cnt", emit_q.size(), 0);
        check("fw_len", sym_len, 2);
        ev_char();
        idle(1);
        check("fw_char_cnt", emit_q.size(), 1);
        if (emit_q.size() > 0) check("fw_char", emit_q[0], 8'h41);

        // Reset during ACK with a symbol buffered.
        emit_q.delete(); emit_cyc.delete();
        ev_dot();
        @(posedge clk); #1;
        writing = 1'b1; dash = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!read && n < 10);
        check("rack_read", read, 1);
        check("rack_len", sym_len, 2);
        #2 reset = 1'b0;
        #1;
        check("rack_read_clr", read, 0);
        check("rack_len_clr", sym_len, 0);
        check("rack_char_clr", char_out, 8'h00);
        writing = 1'b0; dash = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        idle(4);
        check("rack_no_emit", emit_q.size(), 0);
        ev_word();
        idle(1);
        check("rack_no_space", emit_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 Parameter MAX_LEN, default 5, maximum dot/dash elements per symbol.
REQ-002 Parameter CHAR_ERR, default 8'h3F ('?'), code emitted for an unknown or overlong symbol.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 dot  input  1  upstream flag: last press was short.
REQ-006 dash  input  1  upstream flag: last press was long.
REQ-007 interchar  input  1  upstream flag: last gap was a character boundary.
REQ-008 interword  input  1  upstream flag: last gap was a word boundary.
REQ-009 writing  input  1  upstream event-pending strobe; flags are valid one cycle after its rise.
REQ-010 flush  input  1  one-cycle request to emit the pending symbol without a boundary event.
REQ-011 read  output  1  acknowledge to upstream; upstream clears writing on seeing it.
REQ-012 char_out  output  8  ASCII code of the decoded character.
REQ-013 char_valid  output  1  one-cycle pulse qualifying char_out.
REQ-014 sym_len  output  3  number of elements currently buffered, for debug/display.

Function
REQ-015 FSM states: IDLE, SETTLE, ACK, SPACE.
REQ-016 IDLE: writing=1 -> SETTLE; otherwise, flush=1 with sym_len>0 -> emit symbol, stay IDLE; writing has priority over flush, and the flush is dropped.
REQ-017 SETTLE lasts exactly one cycle; flags are sampled on that edge and the FSM goes to ACK.
REQ-018 Sample priority: interword > interchar > dash > dot; all zero = intra-symbol gap, no action.
REQ-019 dot/dash: append the element (dot=0, dash=1) into the symbol shift register, LSB-first arrival order, and increment sym_len.
REQ-020 Append when sym_len=MAX_LEN: set the overflow flag, sym_len saturates, and later elements are discarded.
REQ-021 interchar with sym_len>0: char_valid=1 and char_out=LUT(symbol), or CHAR_ERR if overflowed, in the cycle entering ACK; clear symbol, sym_len, overflow.
REQ-022 interchar with sym_len=0: no emission.
REQ-023 interword: emit the pending symbol as in REQ-021 if any. Then, if word_open, emit 8'h20 via SPACE exactly one cycle later and go to ACK.
REQ-024 word_open is set by any character emission and cleared by a space emission, so there are no repeated or leading spaces.
REQ-025 ACK: read=1 held until writing=0, then read=0 and the FSM goes to IDLE (four-phase handshake). Minimum read width is 1 cycle.
REQ-026 read=1 also in SPACE; read is never 1 in IDLE or SETTLE.
REQ-027 char_valid is never high two consecutive cycles except char followed by space (REQ-023).
REQ-028 LUT covers A-Z and 0-9 (ITU); every other length/pattern combination maps to CHAR_ERR.
REQ-029 char_out holds its last value between pulses.

Reset
REQ-030 reset=0 asynchronously forces IDLE, read=0, char_valid=0, char_out=8'h00, sym_len=0, overflow=0, word_open=0, symbol register 0.
REQ-031 Reset asserted mid-SETTLE/ACK/SPACE aborts the event; no char_valid pulse occurs on the release cycle.
REQ-032 After release, the first rising edge evaluates IDLE normally.

Structure
REQ-033 Shared package morse_pkg holds the FSM state encoding, MAX_LEN default, ASCII constants (space, '?') and symbol-length width.
REQ-034 Sub-module morse_lut: combinational, inputs symbol bits + length, output 8-bit ASCII and a valid bit.

Verification
REQ-035 "E": writing with dot, then writing with interchar -> char_valid once, char_out=8'h45.
REQ-036 "A" then interword: dot, dash, interword -> 8'h41, then 8'h20 on the next cycle; read high until writing drops.
REQ-037 "0": five dashes, interchar -> 8'h30; six dots, interchar -> 8'h3F.
REQ-038 Two interword events with no symbol between -> exactly one 8'h20, no leading space after reset.
REQ-039 flush in IDLE with "T" (one dash) buffered -> 8'h54. flush coincident with writing rise -> no emission, event processed.
REQ-040 Reset pulled low during ACK with a symbol buffered -> read=0 and sym_len=0 immediately, no char_valid after release.
